// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters read by fetch,
// trained by execute-stage branch resolutions, plus branch/mispredict counters.
module branch_predict_unit #(
  parameter int         WORD_LENGTH = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WORD_LENGTH-1:0] f_pc,
  output logic                   f_pred_taken,
  input  logic                   e_valid,
  input  logic [6:0]             e_opcode,
  input  logic [2:0]             e_func3,
  input  logic [WORD_LENGTH-1:0] e_dataA,
  input  logic [WORD_LENGTH-1:0] e_dataB,
  input  logic [WORD_LENGTH-1:0] e_pc,
  input  logic                   e_pred_taken,
  input  logic                   clr_stats,
  output logic                   r_valid,
  output logic                   r_taken,
  output logic                   r_mispredict,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Valid-only protocol, no backpressure: e_valid qualifies the execute-stage
  // fields for exactly the cycle it is high, and r_valid qualifies
  // r_taken/r_mispredict for exactly one cycle, one edge after the branch.

  logic [1:0]       r_bht [BHT_ENTRIES];
  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_e_idx;
  logic             w_is_cond;
  logic             w_is_branch;
  logic             w_taken;
  logic             w_mispredict;
  logic [1:0]       w_cnt;
  logic [1:0]       w_cnt_next;
  logic             w_unused;

  assign w_f_idx = f_pc[IDX_W+1:2];
  assign w_e_idx = e_pc[IDX_W+1:2];

  // Reads the stored counter directly, so a same-cycle update is not visible.
  assign f_pred_taken = r_bht[w_f_idx][1];

  assign w_unused = ^{f_pc[WORD_LENGTH-1:IDX_W+2], f_pc[1:0],
                      e_pc[WORD_LENGTH-1:IDX_W+2], e_pc[1:0]};

  always_comb begin
    w_is_cond = 1'b1;
    w_taken   = 1'b0;
    case (e_func3)
      3'b000:  w_taken = (e_dataA == e_dataB);
      3'b001:  w_taken = (e_dataA != e_dataB);
      3'b100:  w_taken = ($signed(e_dataA) <  $signed(e_dataB));
      3'b101:  w_taken = ($signed(e_dataA) >= $signed(e_dataB));
      3'b110:  w_taken = (e_dataA <  e_dataB);
      3'b111:  w_taken = (e_dataA >= e_dataB);
      default: w_is_cond = 1'b0;
    endcase
  end

  assign w_is_branch  = e_valid && (e_opcode == OPC_BRANCH) && w_is_cond;
  assign w_mispredict = w_taken ^ e_pred_taken;

  assign w_cnt = r_bht[w_e_idx];

  always_comb begin
    w_cnt_next = w_cnt;
    if (w_taken) begin
      if (w_cnt != 2'b11) w_cnt_next = w_cnt + 2'd1;
    end else begin
      if (w_cnt != 2'b00) w_cnt_next = w_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= INIT_STATE;
    end else if (w_is_branch) begin
      r_bht[w_e_idx] <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_valid      <= w_is_branch;
      r_taken      <= w_is_branch & w_taken;
      r_mispredict <= w_is_branch & w_mispredict;
    end
  end

  // A clear in the same cycle as a branch wins; that branch is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else if (clr_stats) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else if (w_is_branch) begin
      if (perf_branches != 32'hFFFF_FFFF)
        perf_branches <= perf_branches + 32'd1;
      if (w_mispredict && (perf_mispredicts != 32'hFFFF_FFFF))
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand-computed outcomes, counter
// trajectories, collision, stats clear and asynchronous reset behaviour.
module tb_branch_predict_unit;

  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [2:0] F_BEQ = 3'b000, F_BNE = 3'b001, F_BLT = 3'b100,
                         F_BGE = 3'b101, F_BLTU = 3'b110, F_BGEU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        e_valid;
  logic [6:0]  e_opcode;
  logic [2:0]  e_func3;
  logic [31:0] e_dataA;
  logic [31:0] e_dataB;
  logic [31:0] e_pc;
  logic        e_pred_taken;
  logic        clr_stats;
  logic        r_valid;
  logic        r_taken;
  logic        r_mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int n_total = 0;
  int n_bad   = 0;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .e_valid(e_valid), .e_opcode(e_opcode), .e_func3(e_func3),
    .e_dataA(e_dataA), .e_dataB(e_dataB), .e_pc(e_pc),
    .e_pred_taken(e_pred_taken), .clr_stats(clr_stats),
    .r_valid(r_valid), .r_taken(r_taken), .r_mispredict(r_mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // drive one execute-stage instruction for a single edge, then idle
  task automatic drive_instr(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] a,
                             input logic [31:0] b, input logic pred);
    e_valid = v; e_opcode = opc; e_func3 = f3; e_pc = pc;
    e_dataA = a; e_dataB = b; e_pred_taken = pred;
    @(posedge clk); #1;
    e_valid = 1'b0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic pred);
    drive_instr(1'b1, OPC_BR, f3, pc, a, b, pred);
  endtask

  task automatic check_res(input string tag, input logic v, input logic t, input logic m);
    check({tag, ".valid"}, {31'd0, r_valid}, {31'd0, v});
    check({tag, ".taken"}, {31'd0, r_taken}, {31'd0, t});
    check({tag, ".misp"},  {31'd0, r_mispredict}, {31'd0, m});
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    f_pc = pc; #1;
    check(tag, {31'd0, f_pred_taken}, {31'd0, exp});
  endtask

  task automatic check_perf(input string tag, input logic [31:0] br, input logic [31:0] mis);
    check({tag, ".br"},  perf_branches, br);
    check({tag, ".mis"}, perf_mispredicts, mis);
  endtask

  initial begin
    rst_n = 1'b0; f_pc = 32'h100; e_valid = 1'b0; e_opcode = 7'd0; e_func3 = 3'd0;
    e_dataA = 32'd0; e_dataB = 32'd0; e_pc = 32'd0; e_pred_taken = 1'b0; clr_stats = 1'b0;
    #22;
    check_res("reset", 1'b0, 1'b0, 1'b0);
    check_perf("reset", 32'd0, 32'd0);
    check_pred("reset.pred100", 32'h100, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // first branch trains 0x100 from 01 to 10
    branch(F_BEQ, 32'h100, 32'd5, 32'd5, 1'b0);
    check_res("beq1", 1'b1, 1'b1, 1'b1);
    check_pred("beq1.pred", 32'h100, 1'b1);
    check_perf("beq1", 32'd1, 32'd1);

    // compare operators, distinct indices
    branch(F_BLT, 32'h104, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_res("blt", 1'b1, 1'b1, 1'b1);
    branch(F_BLTU, 32'h108, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_res("bltu", 1'b1, 1'b0, 1'b0);
    branch(F_BGEU, 32'h10C, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check_res("bgeu", 1'b1, 1'b1, 1'b0);
    branch(F_BNE, 32'h110, 32'd3, 32'd3, 1'b1);
    check_res("bne", 1'b1, 1'b0, 1'b1);
    branch(F_BGE, 32'h114, 32'd1, 32'hFFFF_FFFF, 1'b0);
    check_res("bge", 1'b1, 1'b1, 1'b1);
    check_perf("ops", 32'd6, 32'd4);
    check_pred("bltu.pred", 32'h108, 1'b0);

    // saturation at 11: 01->10->11->11->11, then 10 (taken), then 01 (not taken)
    for (int i = 0; i < 4; i++) branch(F_BEQ, 32'h140, 32'd7, 32'd7, 1'b1);
    check_pred("sat_hi.pred", 32'h140, 1'b1);
    branch(F_BEQ, 32'h140, 32'd7, 32'd8, 1'b1);
    check_res("sat_hi.nt", 1'b1, 1'b0, 1'b1);
    check_pred("sat_hi.10", 32'h140, 1'b1);
    branch(F_BEQ, 32'h140, 32'd7, 32'd8, 1'b1);
    check_pred("sat_hi.01", 32'h140, 1'b0);
    check_perf("sat_hi", 32'd12, 32'd6);

    // saturation at 00: 01->00->00, then taken 01, then taken 10
    for (int i = 0; i < 2; i++) branch(F_BNE, 32'h180, 32'd9, 32'd9, 1'b0);
    branch(F_BNE, 32'h180, 32'd9, 32'd1, 1'b0);
    check_pred("sat_lo.01", 32'h180, 1'b0);
    branch(F_BNE, 32'h180, 32'd9, 32'd1, 1'b0);
    check_pred("sat_lo.10", 32'h180, 1'b1);
    check_perf("sat_lo", 32'd16, 32'd8);

    // non-branches at 0x140 (counter 01): nothing may change
    drive_instr(1'b1, OPC_BR, 3'b010, 32'h140, 32'd4, 32'd4, 1'b1);
    check_res("f3_010", 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, OPC_BR, 3'b011, 32'h140, 32'd4, 32'd4, 1'b1);
    check_res("f3_011", 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 7'b0110011, F_BEQ, 32'h140, 32'd4, 32'd4, 1'b0);
    check_res("alu_op", 1'b0, 1'b0, 1'b0);
    drive_instr(1'b0, OPC_BR, F_BEQ, 32'h140, 32'd4, 32'd4, 1'b0);
    check_res("novalid", 1'b0, 1'b0, 1'b0);
    check_pred("nobr.pred", 32'h140, 1'b0);
    check_perf("nobr", 32'd16, 32'd8);

    // stats clear alone, then 3 branches (1 mispredict), then clear + 4th branch
    clr_stats = 1'b1; @(posedge clk); #1; clr_stats = 1'b0;
    check_perf("clr", 32'd0, 32'd0);
    branch(F_BEQ, 32'h1C0, 32'd1, 32'd1, 1'b1);
    branch(F_BEQ, 32'h1C4, 32'd1, 32'd1, 1'b0);
    branch(F_BNE, 32'h1C8, 32'd1, 32'd1, 1'b0);
    check_perf("three", 32'd3, 32'd1);
    clr_stats = 1'b1;
    branch(F_BEQ, 32'h1CC, 32'd2, 32'd2, 1'b0);
    clr_stats = 1'b0;
    check_res("clr_br", 1'b1, 1'b1, 1'b1);
    check_perf("clr_br", 32'd0, 32'd0);
    check_pred("clr_br.bht", 32'h1CC, 1'b1);

    // reset asserted while a branch at 0x200 is in flight
    branch(F_BEQ, 32'h1D0, 32'd0, 32'd0, 1'b1);
    check_res("pre_rst", 1'b1, 1'b1, 1'b0);
    e_valid = 1'b1; e_opcode = OPC_BR; e_func3 = F_BEQ; e_pc = 32'h200;
    e_dataA = 32'd6; e_dataB = 32'd6; e_pred_taken = 1'b0;
    #2; rst_n = 1'b0; #1;
    check_res("mid_rst", 1'b0, 1'b0, 1'b0);
    check_perf("mid_rst", 32'd0, 32'd0);
    @(posedge clk); #1; e_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_pred("mid_rst.bht", 32'h200, 1'b0);
    check_pred("mid_rst.1cc", 32'h1CC, 1'b0);
    @(posedge clk); #1;
    check_res("post_rst", 1'b0, 1'b0, 1'b0);

    // fetch/execute collision at 0x200 with counter 01: no bypass
    f_pc = 32'h200;
    e_valid = 1'b1; e_opcode = OPC_BR; e_func3 = F_BEQ; e_pc = 32'h200;
    e_dataA = 32'd3; e_dataB = 32'd3; e_pred_taken = 1'b0;
    #1;
    check("coll.same", {31'd0, f_pred_taken}, 32'd0);
    @(posedge clk); #1; e_valid = 1'b0;
    check("coll.next", {31'd0, f_pred_taken}, 32'd1);
    check_res("coll", 1'b1, 1'b1, 1'b1);
    check_perf("coll", 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
